// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control decoder),
// FSM states and the default datapath width.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_RELU = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH cycles.
// done_o/prod_o are combinational on the final iteration so the caller registers them.
module seq_mul #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                  r_busy;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign done_o    = r_busy && (r_cnt == LAST);
  // The product includes the final iteration's add, so it is valid on the done edge.
  assign prod_o    = w_acc_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start_i) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (done_o) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle ADD/SUB/AND/OR/RELU, iterative MUL,
// valid/ready handshake and registered result/zero flag.
module multicycle_alu #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            ALUCtrl_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  zero_o
);

  import alu_pkg::*;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_mul_done;
  logic [DATA_WIDTH-1:0] w_res;
  logic [DATA_WIDTH-1:0] w_prod;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_zero;

  // Unlisted codes (000, 101) fall through to ADD.
  always_comb begin
    w_res = data1_i + data2_i;
    case (ALUCtrl_i)
      ALU_SUB:  w_res = data1_i - data2_i;
      ALU_AND:  w_res = data1_i & data2_i;
      ALU_OR:   w_res = data1_i | data2_i;
      ALU_RELU: w_res = data1_i[DATA_WIDTH-1] ? '0 : data1_i;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o  = 1'b1;
        w_accept = valid_i && !flush_i;
        if (w_accept && (ALUCtrl_i == ALU_MUL)) begin
          w_start     = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL:     if (w_mul_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  seq_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_start),
    .abort_i (flush_i),
    .a_i     (data1_i),
    .b_i     (data2_i),
    .done_o  (w_mul_done),
    .prod_o  (w_prod)
  );

  // data/zero only move on a result-producing edge; flush just kills the pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept && !w_start) begin
        r_data  <= w_res;
        r_zero  <= (w_res == '0);
        r_valid <= 1'b1;
      end else if ((r_state == MUL) && w_mul_done && !flush_i) begin
        r_data  <= w_prod;
        r_zero  <= (w_prod == '0);
        r_valid <= 1'b1;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign zero_o  = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench: constant vector table, directed multi-cycle sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_multicycle_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, vin, rdy, vout, zero;
  logic [2:0]   ctrl;
  logic [W-1:0] a, b, dout;

  int total = 0;
  int bad   = 0;

  // Model state: cycles left on the multiply, pending product, expected outputs.
  int           m_left  = 0;
  logic [W-1:0] m_prod  = '0;
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;
  logic         m_zero  = 1'b0;

  always #5 clk = ~clk;

  multicycle_alu #(.DATA_WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .valid_i   (vin),
    .ready_o   (rdy),
    .ALUCtrl_i (ctrl),
    .data1_i   (a),
    .data2_i   (b),
    .valid_o   (vout),
    .data_o    (dout),
    .zero_o    (zero)
  );

  function automatic logic [W-1:0] ref_op(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    case (c)
      3'b010:  return x - y;
      3'b011:  return x & y;
      3'b100:  return x | y;
      3'b110:  return x * y;
      3'b111:  return x[W-1] ? '0 : x;
      default: return x + y;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare all outputs.
  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    rst = r; flush = f; vin = v; ctrl = c; a = x; b = y;
    #1;
    if (!r) chk("ready", {31'b0, rdy}, {31'b0, (m_left == 0)});
    @(posedge clk);
    if (r) begin
      m_left = 0; m_valid = 1'b0; m_data = '0; m_zero = 1'b0;
    end else if (f) begin
      m_left = 0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_data = m_prod; m_zero = (m_prod == '0); m_valid = 1'b1;
        end
      end else if (v) begin
        if (c == 3'b110) begin
          m_prod = x * y; m_left = W;
        end else begin
          m_data = ref_op(c, x, y); m_zero = (m_data == '0); m_valid = 1'b1;
        end
      end
    end
    #1;
    chk("valid", {31'b0, vout}, {31'b0, m_valid});
    chk("data",  dout, m_data);
    chk("zero",  {31'b0, zero}, {31'b0, m_zero});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'b001, '0, '0);
  endtask

  typedef struct {
    logic [2:0]   c;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp;
    logic         z;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{3'b001, 32'd5,        32'd7,        32'd12,       1'b0};
    vt[1]  = '{3'b010, 32'd5,        32'd5,        32'd0,        1'b1};
    vt[2]  = '{3'b011, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0};
    vt[3]  = '{3'b100, 32'h1,        32'h8,        32'h9,        1'b0};
    vt[4]  = '{3'b111, 32'h80000000, 32'h5,        32'h0,        1'b1};
    vt[5]  = '{3'b111, 32'h7FFFFFFF, 32'h5,        32'h7FFFFFFF, 1'b0};
    vt[6]  = '{3'b000, 32'd2,        32'd3,        32'd5,        1'b0};
    vt[7]  = '{3'b101, 32'd2,        32'd3,        32'd5,        1'b0};
    vt[8]  = '{3'b010, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vt[9]  = '{3'b110, 32'd7,        32'd6,        32'd42,       1'b0};
    vt[10] = '{3'b110, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
    vt[11] = '{3'b110, 32'h10000,    32'h10000,    32'h0,        1'b1};

    cycle(1'b1, 1'b0, 1'b0, 3'b001, '0, '0);
    cycle(1'b1, 1'b1, 1'b1, 3'b001, 32'd1, 32'd1);

    // Non-MUL entries are issued on consecutive cycles (back-to-back throughput).
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b1, vt[i].c, vt[i].x, vt[i].y);
      if (vt[i].c == 3'b110) begin
        vin = 1'b0;
        idle(W);
      end
      chk($sformatf("vec%0d_valid", i), {31'b0, vout}, 32'd1);
      chk($sformatf("vec%0d_data", i), dout, vt[i].exp);
      chk($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vt[i].z});
    end
    idle(2);

    // ADD held on valid_i while MUL is busy: accepted only after MUL returns.
    cycle(1'b0, 1'b0, 1'b1, 3'b110, 32'd7, 32'd6);
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b0, 1'b1, 3'b001, 32'd100, 32'd1);
    chk("mul_then_add_mul", dout, 32'd42);
    cycle(1'b0, 1'b0, 1'b1, 3'b001, 32'd100, 32'd1);
    chk("mul_then_add_add", dout, 32'd101);
    idle(2);

    // Flush at MUL iteration 10: result discarded, data_o held.
    cycle(1'b0, 1'b0, 1'b1, 3'b110, 32'd3, 32'd3);
    idle(9);
    cycle(1'b0, 1'b1, 1'b0, 3'b001, '0, '0);
    idle(W + 2);
    chk("flush_mul_hold", dout, 32'd101);

    // Reset at MUL iteration 20.
    cycle(1'b0, 1'b0, 1'b1, 3'b110, 32'd3, 32'd3);
    idle(19);
    cycle(1'b1, 1'b0, 1'b0, 3'b001, '0, '0);
    chk("rst_mul_data", dout, 32'd0);
    idle(W + 2);

    // Flush with a same-cycle ADD request: dropped.
    cycle(1'b0, 1'b0, 1'b1, 3'b001, 32'd1, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 3'b001, 32'd9, 32'd9);
    chk("flush_drop_valid", {31'b0, vout}, 32'd0);
    chk("flush_drop_data", dout, 32'd2);
    idle(2);

    // MUL completing on a flush edge: flush wins.
    cycle(1'b0, 1'b0, 1'b1, 3'b110, 32'd5, 32'd5);
    idle(W - 1);
    cycle(1'b0, 1'b1, 1'b0, 3'b001, '0, '0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, f, v;
      logic [2:0] c;
      logic [W-1:0] x, y;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 7);
      c = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      cycle(r, f, v, c, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
